scariv_brtag_allocator: RTL and testbench
=========================================

Name: scariv_brtag_allocator

Overview:
- Allocates, tracks and frees branch tags (brtags). Each brtag indexes one slot of the rename snapshot RAM.
- Sits between dispatch and the BRU snapshot store.
  - At dispatch it hands out tags in age order and raises the snapshot write enables.
  - On branch resolution it retires tags, or rolls them back on a mispredict and requests an RMT restore.
- Entries form a circular queue: head is the oldest in-flight branch, tail is the next tag to allocate.

Parameters:
- ENTRY_SIZE, 8, number of brtags and snapshot slots; must be a power of two, minimum 4.
- DISP_SIZE, 4, dispatch slots per cycle.
- BRU_DISP_SIZE, 2, maximum branches allocated per cycle.
- TAG_W, $clog2(ENTRY_SIZE), brtag width (derived).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_disp_valid  in  1  dispatch group valid.
- i_disp_br  in  DISP_SIZE  per-slot: slot carries a branch needing a tag.
- o_disp_ready  out  1  group accepted this cycle.
- o_brtag  out  DISP_SIZE*TAG_W  tag per slot; slot k occupies bits [k*TAG_W +: TAG_W].
- o_snap_wr  out  DISP_SIZE  snapshot write enable per slot.
- i_res_valid  in  1  branch resolution valid.
- i_res_brtag  in  TAG_W  resolved tag.
- i_res_mispred  in  1  resolved branch mispredicted.
- i_flush  in  1  pipeline flush; frees all tags.
- o_restore_valid  out  1  RMT restore request pulse.
- o_restore_brtag  out  TAG_W  snapshot slot to restore from.
- o_free_cnt  out  TAG_W+1  free tag count.
- o_full  out  1  free count is 0.
- o_empty  out  1  no tag in flight.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All state is clocked on the rising edge of i_clk.
- State:
  - r_head and r_tail, each TAG_W+1 bits including a wrap bit.
  - r_valid[ENTRY_SIZE] and r_done[ENTRY_SIZE].
  - r_restore_valid and r_restore_brtag.
- In-flight count = r_tail - r_head, modulo 2^(TAG_W+1).
- o_free_cnt = ENTRY_SIZE - count. o_full = (o_free_cnt == 0). o_empty = (count == 0).
- Reset values:
  - Pointers 0, valid/done all 0, o_restore_valid 0, o_restore_brtag 0.
  - So o_free_cnt = ENTRY_SIZE, o_empty = 1, o_full = 0.
- Dispatch (combinational):
  - n = popcount(i_disp_br).
  - o_disp_ready = !i_flush & !(i_res_valid & i_res_mispred) & (n <= BRU_DISP_SIZE) & (n <= registered o_free_cnt).
  - n > BRU_DISP_SIZE holds ready low; upstream must split the group.
  - A non-branch group (n = 0) is always ready unless flush or mispredict is active.
- Allocation:
  - Fire = i_disp_valid & o_disp_ready.
  - The j-th set bit of i_disp_br, counted from slot 0, gets tag (r_tail + j) mod ENTRY_SIZE.
  - Non-branch slots drive tag 0.
  - o_snap_wr = i_disp_br gated by fire.
  - On fire, set r_valid for each allocated tag, clear its r_done, and advance r_tail by n.
- Correct resolution (i_res_valid & !i_res_mispred): set r_done[tag]. A resolution of a tag that is not valid is ignored.
- Retire:
  - Each cycle, head advances over up to 2 contiguous valid&done entries starting at head, clearing their valid and done bits.
  - Freed tags become allocatable the next cycle; ready uses the registered count.
- Mispredict (i_res_valid & i_res_mispred on a valid tag t):
  - r_tail <= position of t + 1. Its wrap bit is chosen so that the new count = ((t - head) mod ENTRY_SIZE) + 1.
  - Clear valid and done on all entries strictly younger than t; set r_done[t].
  - Next cycle: o_restore_valid = 1 and o_restore_brtag = t, for one cycle only.
  - Retire of already-done older entries proceeds in the same cycle.
  - A mispredict on an invalid tag is ignored: no restore, no state change.
- Flush (i_flush): highest priority. Next cycle head = tail = 0, valid and done all cleared, restore pulse suppressed. Same-cycle resolution and allocation are dropped.
- Wrap-around: pointer indices wrap modulo ENTRY_SIZE; the wrap bit distinguishes full from empty.
- Simultaneous correct resolution and allocation in the same cycle: both take effect.
- Resolving a tag allocated in the same cycle is illegal and is not checked.
- Reset asserted mid-operation returns all state to reset values immediately; no restore pulse follows.

Test Plan:
- Reset, then dispatch i_disp_br = 4'b0101 -> ready = 1, o_brtag slot0 = 0 and slot2 = 1, o_snap_wr = 0101; next cycle o_free_cnt = 6.
- Dispatch i_disp_br = 4'b0111 -> ready = 0 (n = 3 > BRU_DISP_SIZE), tail unchanged.
- Allocate 8 tags with no resolves -> o_full = 1; a further branch group gets ready = 0, while a non-branch group gets ready = 1.
- Allocate tags 0-5, resolve tag 0 correct, then tag 1 correct -> head advances to 2 within 2 cycles; o_free_cnt goes 2 -> 4.
- Allocate tags 0-5, mispredict tag 2 -> next cycle o_restore_valid = 1, o_restore_brtag = 2, count = 3, and the next allocation returns tag 3; a dispatch in the mispredict cycle sees ready = 0.
- Wrap case: with head = 6, allocate tags 6, 7, 0, 1, then mispredict tag 7 -> count = 2, next tag = 0; then assert i_flush -> o_empty = 1, o_free_cnt = 8, no restore pulse.

Source files
------------

// File: rtl/scariv_brtag_allocator_if.sv
// Dispatch / resolution bundle between the branch-tag allocator and its
// neighbours; master is the pipeline side, slave is the allocator.
interface scariv_brtag_allocator_if #(
  parameter int ENTRY_SIZE = 8,
  parameter int DISP_SIZE  = 4,
  parameter int TAG_W      = $clog2(ENTRY_SIZE)
);
  logic                       i_disp_valid;
  logic [DISP_SIZE-1:0]       i_disp_br;
  logic                       o_disp_ready;
  logic [DISP_SIZE*TAG_W-1:0] o_brtag;
  logic [DISP_SIZE-1:0]       o_snap_wr;
  logic                       i_res_valid;
  logic [TAG_W-1:0]           i_res_brtag;
  logic                       i_res_mispred;
  logic                       i_flush;
  logic                       o_restore_valid;
  logic [TAG_W-1:0]           o_restore_brtag;
  logic [TAG_W:0]             o_free_cnt;
  logic                       o_full;
  logic                       o_empty;

  modport master (
    output i_disp_valid, i_disp_br,
    output i_res_valid, i_res_brtag,
    output i_res_mispred, i_flush,
    input  o_disp_ready, o_brtag, o_snap_wr,
    input  o_restore_valid, o_restore_brtag,
    input  o_free_cnt, o_full, o_empty
  );

  modport slave (
    input  i_disp_valid, i_disp_br,
    input  i_res_valid, i_res_brtag,
    input  i_res_mispred, i_flush,
    output o_disp_ready, o_brtag, o_snap_wr,
    output o_restore_valid, o_restore_brtag,
    output o_free_cnt, o_full, o_empty
  );
endinterface

// File: rtl/scariv_brtag_allocator.sv
// Branch-tag allocator: circular queue of snapshot slots handed out in
// age order, retired in order, rolled back on a mispredict.
module scariv_brtag_allocator #(
  parameter int ENTRY_SIZE    = 8,
  parameter int DISP_SIZE     = 4,
  parameter int BRU_DISP_SIZE = 2,
  parameter int TAG_W         = $clog2(ENTRY_SIZE)
) (
  input logic i_clk,
  input logic i_reset,
  scariv_brtag_allocator_if.slave bus
);

  localparam int PW  = TAG_W + 1;
  localparam int CW0 = $clog2(DISP_SIZE + 1);
  localparam int NW  = (CW0 > PW) ? CW0 : PW;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PW-1:0]    ptr_t;

  ptr_t                  r_head, r_tail;
  ptr_t                  head_n, tail_n;
  logic [ENTRY_SIZE-1:0] r_valid, r_done;
  logic [ENTRY_SIZE-1:0] valid_n, done_n;
  logic                  r_restore_valid;
  tag_t                  r_restore_brtag;

  ptr_t                       cnt, free_cnt;
  logic [NW-1:0]              n_br;
  tag_t                       alloc_tag [DISP_SIZE];
  logic [DISP_SIZE*TAG_W-1:0] brtag_flat;
  logic                       ready, fire;
  logic                       hit, res_ok, res_mis;
  tag_t                       res_tag, hidx, h1, dist_t, dist_i;
  logic                       ret0, ret1;

  assign cnt      = r_tail - r_head;
  assign free_cnt = ptr_t'(ENTRY_SIZE) - cnt;
  assign hidx     = r_head[TAG_W-1:0];
  assign h1       = hidx + tag_t'(1);

  // j-th branch slot gets tail + j
  always_comb begin
    n_br       = '0;
    brtag_flat = '0;
    for (int k = 0; k < DISP_SIZE; k++) begin
      alloc_tag[k] = '0;
      if (bus.i_disp_br[k]) begin
        alloc_tag[k] = r_tail[TAG_W-1:0] + n_br[TAG_W-1:0];
        n_br         = n_br + NW'(1);
      end
      brtag_flat[k*TAG_W +: TAG_W] = alloc_tag[k];
    end
  end

  assign ready = !bus.i_flush
               & !(bus.i_res_valid & bus.i_res_mispred)
               & (n_br <= NW'(BRU_DISP_SIZE))
               & (n_br <= NW'(free_cnt));
  assign fire  = bus.i_disp_valid & ready;

  assign res_tag = bus.i_res_brtag;
  assign hit     = bus.i_res_valid & r_valid[res_tag];
  assign res_ok  = hit & !bus.i_res_mispred;
  assign res_mis = hit & bus.i_res_mispred;
  assign dist_t  = res_tag - hidx;

  assign ret0 = r_valid[hidx] & r_done[hidx];
  assign ret1 = ret0 & r_valid[h1] & r_done[h1];

  always_comb begin
    valid_n = r_valid;
    done_n  = r_done;
    head_n  = r_head;
    tail_n  = r_tail;
    dist_i  = '0;
    if (fire) begin
      for (int k = 0; k < DISP_SIZE; k++) begin
        if (bus.i_disp_br[k]) begin
          valid_n[alloc_tag[k]] = 1'b1;
          done_n[alloc_tag[k]]  = 1'b0;
        end
      end
      tail_n = r_tail + ptr_t'(n_br);
    end
    if (res_ok) begin
      done_n[res_tag] = 1'b1;
    end
    // squash everything younger than the mispredicted branch
    if (res_mis) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        dist_i = tag_t'(i) - hidx;
        if (dist_i > dist_t) begin
          valid_n[i] = 1'b0;
          done_n[i]  = 1'b0;
        end
      end
      done_n[res_tag] = 1'b1;
      tail_n = r_head + ptr_t'(dist_t) + ptr_t'(1);
    end
    if (ret0) begin
      valid_n[hidx] = 1'b0;
      done_n[hidx]  = 1'b0;
    end
    if (ret1) begin
      valid_n[h1] = 1'b0;
      done_n[h1]  = 1'b0;
    end
    head_n = r_head + ptr_t'(ret0) + ptr_t'(ret1);
    if (bus.i_flush) begin
      valid_n = '0;
      done_n  = '0;
      head_n  = '0;
      tail_n  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_valid         <= '0;
      r_done          <= '0;
      r_restore_valid <= 1'b0;
      r_restore_brtag <= '0;
    end else begin
      r_head          <= head_n;
      r_tail          <= tail_n;
      r_valid         <= valid_n;
      r_done          <= done_n;
      r_restore_valid <= res_mis & !bus.i_flush;
      if (res_mis & !bus.i_flush) begin
        r_restore_brtag <= res_tag;
      end
    end
  end

  assign bus.o_disp_ready    = ready;
  assign bus.o_brtag         = brtag_flat;
  assign bus.o_snap_wr       = bus.i_disp_br & {DISP_SIZE{fire}};
  assign bus.o_restore_valid = r_restore_valid;
  assign bus.o_restore_brtag = r_restore_brtag;
  assign bus.o_free_cnt      = free_cnt;
  assign bus.o_full          = (free_cnt == '0);
  assign bus.o_empty         = (cnt == '0);

endmodule

// File: tb/tb_scariv_brtag_allocator.sv
// Bench for scariv_brtag_allocator: directed plan scenarios plus random
// traffic against an in-order queue model of in-flight branches.
module tb_scariv_brtag_allocator;

  localparam int E  = 8;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scariv_brtag_allocator_if #(.ENTRY_SIZE(E), .DISP_SIZE(D), .TAG_W(TW)) bus ();

  scariv_brtag_allocator #(
    .ENTRY_SIZE(E), .DISP_SIZE(D), .BRU_DISP_SIZE(B), .TAG_W(TW)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  int pass_cnt = 0;
  int total    = 0;

  // model: in-flight branches oldest first
  int mq_tag[$];
  bit mq_done[$];
  int m_next;
  bit m_rv;
  int m_rt;

  bit              exp_ready;
  logic [D*TW-1:0] exp_tags;
  logic [D-1:0]    exp_snap;
  logic [TW:0]     exp_free;
  bit              exp_full, exp_empty, exp_rv;
  logic [TW-1:0]   exp_rt;

  task automatic model_clear();
    mq_tag.delete();
    mq_done.delete();
    m_next = 0;
    m_rv   = 0;
    m_rt   = 0;
  endtask

  task automatic tick(input bit v, input logic [D-1:0] br, input bit rv,
                      input int rt, input bit rm, input bit fl);
    int n, j, fr, ret, idx;
    bit rdy, new_rv;
    logic [31:0] rtv;
    @(negedge clk);
    rtv = rt;
    bus.i_disp_valid  = v;
    bus.i_disp_br     = br;
    bus.i_res_valid   = rv;
    bus.i_res_brtag   = rtv[TW-1:0];
    bus.i_res_mispred = rm;
    bus.i_flush       = fl;
    #1;
    n   = $countones(br);
    fr  = E - mq_tag.size();
    rdy = !fl && !(rv && rm) && n <= B && n <= fr;
    exp_ready = rdy;
    exp_tags  = '0;
    j = 0;
    for (int k = 0; k < D; k++) begin
      if (br[k]) begin
        exp_tags[k*TW +: TW] = TW'((m_next + j) % E);
        j++;
      end
    end
    exp_snap  = (rdy && v) ? br : '0;
    exp_free  = (TW+1)'(fr);
    exp_full  = (fr == 0);
    exp_empty = (mq_tag.size() == 0);
    exp_rv    = m_rv;
    exp_rt    = TW'(m_rt);
    ret = 0;
    if (mq_tag.size() > 0 && mq_done[0]) ret = 1;
    if (ret == 1 && mq_tag.size() > 1 && mq_done[1]) ret = 2;
    if (fl) begin
      mq_tag.delete();
      mq_done.delete();
      m_next = 0;
      m_rv   = 0;
    end else begin
      new_rv = 0;
      if (v && rdy) begin
        for (int k = 0; k < D; k++) begin
          if (br[k]) begin
            mq_tag.push_back(m_next);
            mq_done.push_back(1'b0);
            m_next = (m_next + 1) % E;
          end
        end
      end
      if (rv) begin
        idx = -1;
        for (int i = 0; i < mq_tag.size(); i++) if (mq_tag[i] == rt) idx = i;
        if (idx >= 0) begin
          if (!rm) mq_done[idx] = 1'b1;
          else begin
            while (mq_tag.size() > idx + 1) begin
              void'(mq_tag.pop_back());
              void'(mq_done.pop_back());
            end
            mq_done[idx] = 1'b1;
            m_next = (rt + 1) % E;
            new_rv = 1;
            m_rt   = rt;
          end
        end
      end
      for (int r = 0; r < ret; r++) begin
        void'(mq_tag.pop_front());
        void'(mq_done.pop_front());
      end
      m_rv = new_rv;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_disp_valid  = 0;
    bus.i_disp_br     = '0;
    bus.i_res_valid   = 0;
    bus.i_res_brtag   = '0;
    bus.i_res_mispred = 0;
    bus.i_flush       = 0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (bus.o_free_cnt !== 4'd8) $display("FAIL reset_free got=%0d exp=8", bus.o_free_cnt); else pass_cnt++;
    total++; if (bus.o_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.o_empty); else pass_cnt++;
    total++; if (bus.o_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.o_full); else pass_cnt++;
    total++; if (bus.o_restore_valid !== 1'b0) $display("FAIL reset_rv got=%b exp=0", bus.o_restore_valid); else pass_cnt++;
    total++; if (bus.o_restore_brtag !== 3'd0) $display("FAIL reset_rt got=%0d exp=0", bus.o_restore_brtag); else pass_cnt++;
  endtask

  task automatic test_alloc_basic();
    do_reset();
    tick(1, 4'b0101, 0, 0, 0, 0);
    total++; if (bus.o_disp_ready !== 1'b1) $display("FAIL basic_ready got=%b exp=1", bus.o_disp_ready); else pass_cnt++;
    total++; if (bus.o_brtag[0 +: TW] !== 3'd0) $display("FAIL basic_tag0 got=%0d exp=0", bus.o_brtag[0 +: TW]); else pass_cnt++;
    total++; if (bus.o_brtag[2*TW +: TW] !== 3'd1) $display("FAIL basic_tag2 got=%0d exp=1", bus.o_brtag[2*TW +: TW]); else pass_cnt++;
    total++; if (bus.o_snap_wr !== 4'b0101) $display("FAIL basic_snap got=%b exp=0101", bus.o_snap_wr); else pass_cnt++;
    tick(1, 4'b0111, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd6) $display("FAIL basic_free got=%0d exp=6", bus.o_free_cnt); else pass_cnt++;
    total++; if (bus.o_disp_ready !== 1'b0) $display("FAIL three_br_ready got=%b exp=0", bus.o_disp_ready); else pass_cnt++;
    total++; if (bus.o_snap_wr !== 4'b0000) $display("FAIL three_br_snap got=%b exp=0000", bus.o_snap_wr); else pass_cnt++;
    tick(1, 4'b1000, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd6) $display("FAIL three_br_free got=%0d exp=6", bus.o_free_cnt); else pass_cnt++;
    total++; if (bus.o_brtag[3*TW +: TW] !== 3'd2) $display("FAIL three_br_next got=%0d exp=2", bus.o_brtag[3*TW +: TW]); else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 4'b0011, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_full !== 1'b1) $display("FAIL full_flag got=%b exp=1", bus.o_full); else pass_cnt++;
    total++; if (bus.o_free_cnt !== 4'd0) $display("FAIL full_free got=%0d exp=0", bus.o_free_cnt); else pass_cnt++;
    tick(1, 4'b0001, 0, 0, 0, 0);
    total++; if (bus.o_disp_ready !== 1'b0) $display("FAIL full_br_ready got=%b exp=0", bus.o_disp_ready); else pass_cnt++;
    tick(1, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_disp_ready !== 1'b1) $display("FAIL full_nobr_ready got=%b exp=1", bus.o_disp_ready); else pass_cnt++;
  endtask

  task automatic test_retire();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 4'b0011, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd2) $display("FAIL retire_free0 got=%0d exp=2", bus.o_free_cnt); else pass_cnt++;
    tick(0, 4'b0000, 1, 0, 0, 0);
    tick(0, 4'b0000, 1, 1, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd3) $display("FAIL retire_free1 got=%0d exp=3", bus.o_free_cnt); else pass_cnt++;
    tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd4) $display("FAIL retire_free2 got=%0d exp=4", bus.o_free_cnt); else pass_cnt++;
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 4'b0011, 0, 0, 0, 0);
    tick(1, 4'b0001, 1, 2, 1, 0);
    total++; if (bus.o_disp_ready !== 1'b0) $display("FAIL mis_ready got=%b exp=0", bus.o_disp_ready); else pass_cnt++;
    tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_restore_valid !== 1'b1) $display("FAIL mis_rv got=%b exp=1", bus.o_restore_valid); else pass_cnt++;
    total++; if (bus.o_restore_brtag !== 3'd2) $display("FAIL mis_rt got=%0d exp=2", bus.o_restore_brtag); else pass_cnt++;
    total++; if (bus.o_free_cnt !== 4'd5) $display("FAIL mis_free got=%0d exp=5", bus.o_free_cnt); else pass_cnt++;
    tick(1, 4'b0001, 0, 0, 0, 0);
    total++; if (bus.o_restore_valid !== 1'b0) $display("FAIL mis_rv_pulse got=%b exp=0", bus.o_restore_valid); else pass_cnt++;
    total++; if (bus.o_brtag[0 +: TW] !== 3'd3) $display("FAIL mis_next_tag got=%0d exp=3", bus.o_brtag[0 +: TW]); else pass_cnt++;
    tick(0, 4'b0000, 1, 1, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.o_restore_valid !== 1'b0) $display("FAIL rst_mid_rv got=%b exp=0", bus.o_restore_valid); else pass_cnt++;
    total++; if (bus.o_free_cnt !== 4'd8) $display("FAIL rst_mid_free got=%0d exp=8", bus.o_free_cnt); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 4'b0011, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 4'b0000, 1, i, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd8) $display("FAIL wrap_drain got=%0d exp=8", bus.o_free_cnt); else pass_cnt++;
    tick(1, 4'b0011, 0, 0, 0, 0);
    total++; if (bus.o_brtag[2*TW-1:0] !== {3'd7, 3'd6}) $display("FAIL wrap_tags67 got=%h exp=3e", bus.o_brtag[2*TW-1:0]); else pass_cnt++;
    tick(1, 4'b0011, 0, 0, 0, 0);
    total++; if (bus.o_brtag[2*TW-1:0] !== {3'd1, 3'd0}) $display("FAIL wrap_tags01 got=%h exp=08", bus.o_brtag[2*TW-1:0]); else pass_cnt++;
    tick(0, 4'b0000, 1, 7, 1, 0);
    tick(1, 4'b0001, 0, 0, 0, 0);
    total++; if (bus.o_free_cnt !== 4'd6) $display("FAIL wrap_mis_free got=%0d exp=6", bus.o_free_cnt); else pass_cnt++;
    total++; if (bus.o_restore_brtag !== 3'd7) $display("FAIL wrap_mis_rt got=%0d exp=7", bus.o_restore_brtag); else pass_cnt++;
    total++; if (bus.o_brtag[0 +: TW] !== 3'd0) $display("FAIL wrap_next_tag got=%0d exp=0", bus.o_brtag[0 +: TW]); else pass_cnt++;
    tick(1, 4'b0001, 1, 6, 1, 1);
    tick(0, 4'b0000, 0, 0, 0, 0);
    total++; if (bus.o_empty !== 1'b1) $display("FAIL flush_empty got=%b exp=1", bus.o_empty); else pass_cnt++;
    total++; if (bus.o_free_cnt !== 4'd8) $display("FAIL flush_free got=%0d exp=8", bus.o_free_cnt); else pass_cnt++;
    total++; if (bus.o_restore_valid !== 1'b0) $display("FAIL flush_rv got=%b exp=0", bus.o_restore_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    bit v, rv, rm, fl;
    logic [D-1:0] br;
    int rt, cand[$];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      br = D'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) br = br & D'($urandom_range(0, 15));
      rv = 0; rm = 0; rt = 0;
      fl = ($urandom_range(0, 59) == 0);
      cand.delete();
      for (int i = 0; i < mq_tag.size(); i++) if (!mq_done[i]) cand.push_back(mq_tag[i]);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        rv = 1;
        rt = cand[$urandom_range(0, cand.size() - 1)];
        rm = ($urandom_range(0, 5) == 0);
      end else if (mq_tag.size() < E && $urandom_range(0, 9) == 0) begin
        rv = 1; rm = 1;
        do rt = $urandom_range(0, E - 1); while (rt inside {mq_tag});
      end
      tick(v, br, rv, rt, rm, fl);
      total++; if (bus.o_disp_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.o_disp_ready, exp_ready); else pass_cnt++;
      total++; if (bus.o_brtag !== exp_tags) $display("FAIL rnd_brtag cyc=%0d got=%h exp=%h", c, bus.o_brtag, exp_tags); else pass_cnt++;
      total++; if (bus.o_snap_wr !== exp_snap) $display("FAIL rnd_snap cyc=%0d got=%b exp=%b", c, bus.o_snap_wr, exp_snap); else pass_cnt++;
      total++; if (bus.o_free_cnt !== exp_free) $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", c, bus.o_free_cnt, exp_free); else pass_cnt++;
      total++; if ({bus.o_full, bus.o_empty} !== {exp_full, exp_empty}) $display("FAIL rnd_full_empty cyc=%0d got=%b%b exp=%b%b", c, bus.o_full, bus.o_empty, exp_full, exp_empty); else pass_cnt++;
      total++; if (bus.o_restore_valid !== exp_rv) $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", c, bus.o_restore_valid, exp_rv); else pass_cnt++;
      total++; if (bus.o_restore_brtag !== exp_rt) $display("FAIL rnd_rt cyc=%0d got=%0d exp=%0d", c, bus.o_restore_brtag, exp_rt); else pass_cnt++;
    end
  endtask

  initial begin
    bus.i_disp_valid  = 0;
    bus.i_disp_br     = '0;
    bus.i_res_valid   = 0;
    bus.i_res_brtag   = '0;
    bus.i_res_mispred = 0;
    bus.i_flush       = 0;
    model_clear();
    test_reset();
    test_alloc_basic();
    test_full();
    test_retire();
    test_mispredict();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
